// File: rtl/simon_key_schedule.sv
// Simon 32/64 round-key generator.
// Loads a 64-bit master key, then streams ROUNDS 16-bit round keys k0..k(ROUNDS-1)
// over a valid/ready handshake. Each key is derived on the fly from a 4-word sliding window.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   key_in, key_valid    master key {k3,k2,k1,k0}; accepted when key_valid && key_ready
//   key_ready            high while idle
//   rk_out, rk_index     current round key and its index
//   rk_last              marks the final round key
//   rk_valid, rk_ready   round-key handshake
//   busy                 high while streaming
module simon_key_schedule #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [61:0] Z_SEQ  = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [15:0] rk_out,
  output logic [4:0]  rk_index,
  output logic        rk_last,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic        busy
);

  localparam int unsigned KW = 16;
  localparam int unsigned IW = 5;
  localparam int unsigned JW = 6;
  localparam logic [IW-1:0] LAST_IDX = IW'(ROUNDS - 1);
  localparam logic [JW-1:0] J_MAX    = JW'(61);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [KW-1:0] w0, w1, w2, w3;
  logic [KW-1:0] w0_nx, w1_nx, w2_nx, w3_nx;
  logic [IW-1:0] idx_nx;
  logic [JW-1:0] j, j_nx;
  logic [KW-1:0] tmp_a, tmp_b, new_word;
  logic          z_bit;
  logic          load, xfer;

  assign rk_out = w0;
  assign load   = key_valid && key_ready;
  assign xfer   = rk_valid && rk_ready;

  // Next window word; z is stored with z[0] as the MSB of Z_SEQ.
  always_comb begin
    tmp_a    = {w3[2:0], w3[15:3]} ^ w1;
    tmp_b    = tmp_a ^ {tmp_a[0], tmp_a[15:1]};
    z_bit    = Z_SEQ[J_MAX - j];
    new_word = 16'hFFFC ^ {15'b0, z_bit} ^ w0 ^ tmp_b;
  end

  // Next-state and window update.
  always_comb begin
    state_nx = state;
    w0_nx    = w0;
    w1_nx    = w1;
    w2_nx    = w2;
    w3_nx    = w3;
    idx_nx   = rk_index;
    j_nx     = j;
    case (state)
      IDLE: begin
        if (load) begin
          state_nx = RUN;
          w0_nx    = key_in[15:0];
          w1_nx    = key_in[31:16];
          w2_nx    = key_in[47:32];
          w3_nx    = key_in[63:48];
          idx_nx   = '0;
          j_nx     = '0;
        end
      end
      RUN: begin
        if (xfer) begin
          w0_nx  = w1;
          w1_nx  = w2;
          w2_nx  = w3;
          w3_nx  = new_word;
          idx_nx = rk_index + IW'(1);
          j_nx   = (j == J_MAX) ? '0 : j + JW'(1);
          if (rk_index == LAST_IDX) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, window and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      rk_index  <= '0;
      j         <= '0;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_last   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      w0        <= w0_nx;
      w1        <= w1_nx;
      w2        <= w2_nx;
      w3        <= w3_nx;
      rk_index  <= idx_nx;
      j         <= j_nx;
      key_ready <= (state_nx == IDLE);
      rk_valid  <= (state_nx == RUN);
      busy      <= (state_nx == RUN);
      rk_last   <= (state_nx == RUN) && (idx_nx == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_simon_key_schedule.sv
module tb_simon_key_schedule;

  localparam logic [63:0] KEY  = 64'h1918_1110_0908_0100;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_CAFE_F00D;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        key_valid, key_ready;
  logic [15:0] rk_out;
  logic [4:0]  rk_index;
  logic        rk_last, rk_valid, rk_ready, busy;

  logic        key_valid4, key_ready4, rk_last4, rk_valid4, busy4;
  logic [15:0] rk_out4;
  logic [4:0]  rk_index4;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] got_key [32];
  int got_n, stall_err, idx_err, last_err, cyc;
  bit timeout;

  always #5 clk = ~clk;

  simon_key_schedule dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .rk_out(rk_out), .rk_index(rk_index), .rk_last(rk_last), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .busy(busy)
  );

  simon_key_schedule #(.ROUNDS(4)) dut4 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid4), .key_ready(key_ready4),
    .rk_out(rk_out4), .rk_index(rk_index4), .rk_last(rk_last4), .rk_valid(rk_valid4),
    .rk_ready(1'b1), .busy(busy4)
  );

  function automatic logic [15:0] rol(input logic [15:0] x, input int n);
    return (x << n) | (x >> (16 - n));
  endfunction

  // Simon 32/64 encryption of the collected round keys.
  function automatic logic [31:0] encrypt(input logic [15:0] x0, input logic [15:0] y0);
    logic [15:0] x, y, t;
    x = x0; y = y0;
    for (int r = 0; r < 32; r++) begin
      t = x;
      x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ got_key[r];
      y = t;
    end
    return {x, y};
  endfunction

  // Present a key for one cycle; returns at the negedge after the accept edge.
  task automatic load_key(input logic [63:0] k);
    key_in = k; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Drive rk_ready and record transfers until n_target keys or a cycle budget.
  task automatic collect(input bit rand_ready, input int n_target, input int pulse_cycle);
    logic [15:0] prev_out;
    logic [4:0]  prev_idx;
    bit held;
    held = 0; prev_out = '0; prev_idx = '0;
    got_n = 0; stall_err = 0; idx_err = 0; last_err = 0; cyc = 0; timeout = 0;
    while (got_n < n_target) begin
      if (cyc > 400) begin timeout = 1; break; end
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == pulse_cycle) begin key_in = JUNK; key_valid = 1'b1; end
      else key_valid = 1'b0;
      if (rk_valid) begin
        if (held && (rk_out !== prev_out || rk_index !== prev_idx)) stall_err++;
        if (rk_last !== (rk_index == 5'd31)) last_err++;
        if (rk_ready) begin
          if (rk_index !== 5'(got_n)) idx_err++;
          got_key[got_n] = rk_out;
          got_n++;
          held = 0;
        end else begin
          held = 1; prev_out = rk_out; prev_idx = rk_index;
        end
      end
      cyc++;
      @(negedge clk);
    end
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; key_valid4 = 1'b0; rk_ready = 1'b1; key_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({key_ready, rk_valid, rk_last, busy, rk_out, rk_index} !== {4'b1000, 16'h0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy/val/last/busy=%b%b%b%b out=%h idx=%0d, want 1000 0000 0",
               key_ready, rk_valid, rk_last, busy, rk_out, rk_index);
    end
  endtask

  task automatic test_stream();
    logic [15:0] exp5 [5];
    logic [31:0] ct;
    exp5[0] = 16'h0100; exp5[1] = 16'h0908; exp5[2] = 16'h1110;
    exp5[3] = 16'h1918; exp5[4] = 16'h71C3;
    rk_ready = 1'b1;
    load_key(KEY);
    vectors++;
    if (rk_valid !== 1'b1 || busy !== 1'b1 || key_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL first_latency: val=%b busy=%b key_ready=%b, want 1 1 0", rk_valid, busy, key_ready);
    end
    collect(1'b0, 32, -1);
    vectors++;
    if (timeout || got_n != 32 || cyc != 32) begin
      miscompares++;
      $display("FAIL stream_throughput: keys=%0d cycles=%0d timeout=%0d, want 32 32 0", got_n, cyc, timeout);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (got_key[k] !== exp5[k]) begin
        miscompares++;
        $display("FAIL stream_key%0d: got %h want %h", k, got_key[k], exp5[k]);
      end
    end
    vectors++;
    if (idx_err != 0 || last_err != 0) begin
      miscompares++;
      $display("FAIL stream_index_last: idx_err=%0d last_err=%0d, want 0 0", idx_err, last_err);
    end
    ct = encrypt(16'h6565, 16'h6877);
    vectors++;
    if (ct !== 32'hC69B_E9BB) begin
      miscompares++;
      $display("FAIL stream_ciphertext: got %h want c69be9bb", ct);
    end
    rk_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0 || rk_last !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_end_idle: val=%b key_ready=%b busy=%b last=%b, want 0 1 0 0",
               rk_valid, key_ready, busy, rk_last);
    end
    rk_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ready_no_effect: val=%b busy=%b, want 0 0", rk_valid, busy);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ct;
    load_key(KEY);
    collect(1'b1, 32, -1);
    ct = encrypt(16'h6565, 16'h6877);
    vectors++;
    if (timeout || got_n != 32 || stall_err != 0 || idx_err != 0 || last_err != 0) begin
      miscompares++;
      $display("FAIL stall_stream: keys=%0d stall_err=%0d idx_err=%0d last_err=%0d timeout=%0d, want 32 0 0 0 0",
               got_n, stall_err, idx_err, last_err, timeout);
    end
    vectors++;
    if (ct !== 32'hC69B_E9BB) begin
      miscompares++;
      $display("FAIL stall_ciphertext: got %h want c69be9bb", ct);
    end
    rk_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ct;
    load_key(KEY);
    collect(1'b0, 32, 3);
    ct = encrypt(16'h6565, 16'h6877);
    vectors++;
    if (timeout || got_n != 32 || idx_err != 0 || ct !== 32'hC69B_E9BB) begin
      miscompares++;
      $display("FAIL ignore_key_in_run: keys=%0d idx_err=%0d ct=%h, want 32 0 c69be9bb", got_n, idx_err, ct);
    end
    vectors++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: key_ready=%b val=%b, want 1 0", key_ready, rk_valid);
    end
    load_key(KEY);
    vectors++;
    if (rk_valid !== 1'b1 || rk_index !== 5'd0 || rk_out !== 16'h0100) begin
      miscompares++;
      $display("FAIL b2b_restart: val=%b idx=%0d out=%h, want 1 0 0100", rk_valid, rk_index, rk_out);
    end
    collect(1'b0, 32, -1);
    rk_ready = 1'b0;
    @(negedge clk);
    rk_ready = 1'b1;
  endtask

  task automatic test_mid_reset();
    load_key(KEY);
    collect(1'b0, 10, -1);
    vectors++;
    if (rk_valid !== 1'b1 || rk_index !== 5'd10) begin
      miscompares++;
      $display("FAIL pre_reset: val=%b idx=%0d, want 1 10", rk_valid, rk_index);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({key_ready, rk_valid, rk_last, busy, rk_out, rk_index} !== {4'b1000, 16'h0, 5'd0}) begin
      miscompares++;
      $display("FAIL mid_reset: rdy/val/last/busy=%b%b%b%b out=%h idx=%0d, want 1000 0000 0",
               key_ready, rk_valid, rk_last, busy, rk_out, rk_index);
    end
    load_key(KEY);
    vectors++;
    if (rk_valid !== 1'b1 || rk_index !== 5'd0 || rk_out !== 16'h0100) begin
      miscompares++;
      $display("FAIL reload_after_reset: val=%b idx=%0d out=%h, want 1 0 0100", rk_valid, rk_index, rk_out);
    end
    collect(1'b0, 32, -1);
    @(negedge clk);
  endtask

  task automatic test_rounds4();
    logic [15:0] exp4 [4];
    exp4[0] = 16'h0100; exp4[1] = 16'h0908; exp4[2] = 16'h1110; exp4[3] = 16'h1918;
    key_in = KEY; key_valid4 = 1'b1;
    @(negedge clk);
    key_valid4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (rk_valid4 !== 1'b1 || rk_out4 !== exp4[k] || rk_index4 !== 5'(k) || rk_last4 !== (k == 3)) begin
        miscompares++;
        $display("FAIL rounds4_key%0d: val=%b out=%h idx=%0d last=%b, want 1 %h %0d %0d",
                 k, rk_valid4, rk_out4, rk_index4, rk_last4, exp4[k], k, (k == 3));
      end
      @(negedge clk);
    end
    vectors++;
    if (rk_valid4 !== 1'b0 || key_ready4 !== 1'b1 || busy4 !== 1'b0) begin
      miscompares++;
      $display("FAIL rounds4_idle: val=%b key_ready=%b busy=%b, want 0 1 0", rk_valid4, key_ready4, busy4);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_rounds4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/simon_key_schedule.md
Name: simon_key_schedule

Overview:
- Simon 32/64 round-key generator; sits directly upstream of the single-round datapath (16-bit in_key of each round).
- Accepts one 64-bit master key, then streams ROUNDS 16-bit round keys k0..k(ROUNDS-1) in order over a valid/ready handshake, one per cycle when unstalled.
- Round keys are computed on the fly from a 4-word window; no key table is stored.

Parameters:
- ROUNDS, 32, number of round keys emitted per master key; legal range 4..32.
- Z_SEQ, 62'b11111010001001010110000111001101111101000100101011000011100110, Simon z0 constant sequence. The leftmost character is z[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- key_in  input  64  master key: [15:0]=k0, [31:16]=k1, [47:32]=k2, [63:48]=k3.
- key_valid  input  1  master key present.
- key_ready  output  1  high in IDLE only; a load occurs on key_valid&&key_ready.
- rk_out  output  16  current round key k[i].
- rk_index  output  5  i of the key on rk_out.
- rk_last  output  1  high with rk_valid when i==ROUNDS-1.
- rk_valid  output  1  rk_out is valid.
- rk_ready  input  1  consumer accepts the key; a transfer occurs on rk_valid&&rk_ready.
- busy  output  1  high in RUN.

Behaviour:
- Reset is synchronous and active-high; single clock domain on clk.
- Reset values: state=IDLE, key_ready=1, rk_valid=0, rk_last=0, busy=0, rk_out=0, rk_index=0. Window and z pointer are cleared to 0.
- States: IDLE and RUN.
- IDLE -> RUN on key accept at edge t:
  - window w0..w3 <= k0..k3; round counter i <= 0; z pointer j <= 0.
  - From cycle t+1: rk_valid=1, rk_out=k0, rk_index=0. Load-to-first-key latency is 1 cycle.
- RUN, on each transfer:
  - Compute tmp = ror(w3,3) ^ w1, then tmp = tmp ^ ror(tmp,1).
  - new = 16'hFFFC ^ {15'b0, Z_SEQ bit j} ^ w0 ^ tmp.
  - Shift window: w0<=w1, w1<=w2, w2<=w3, w3<=new.
  - i<=i+1; j<=j+1, wrapping 61->0 (unreachable for ROUNDS<=32, but required).
- rk_out is always w0, registered. All arithmetic is 16-bit; rotations are circular right.
- Stall: while rk_valid && !rk_ready, rk_out, rk_index and rk_last hold stable with no state change. The generator must not drop or skip a key.
- Throughput: 1 key per cycle with rk_ready held high; ROUNDS cycles from first rk_valid to last transfer.
- RUN -> IDLE on the transfer with i==ROUNDS-1. Next cycle: rk_valid=0, key_ready=1, busy=0. A new key may be accepted that cycle, so back-to-back key-to-key spacing is ROUNDS+1 cycles.
- key_valid during RUN is ignored, since key_ready=0; key_in is not sampled.
- rk_ready while rk_valid=0 has no effect.
- rst asserted mid-RUN: next cycle is IDLE with the reset values above. Any partial stream is abandoned, and the next key restarts from k0.
- rst has priority over a simultaneous key accept or transfer.

Test Plan:
- Reset, then key_in=64'h1918_1110_0908_0100 with rk_ready=1 -> first keys are 0100, 0908, 1110, 1918, 71C3 with rk_index 0..4. rk_valid rises exactly 1 cycle after accept, and rk_last pulses only with index 31.
- Same key with rk_ready toggled pseudo-randomly -> identical 32-key sequence. rk_out and rk_index are stable during every stall; no duplicate or missing indices.
- Key accepted, then a second key_valid pulse during RUN -> the second key is ignored and the stream is unchanged. After the final transfer, key_ready=1 and a new key starts at index 0 the next cycle.
- rst asserted after 10 transfers -> next cycle rk_valid=0, key_ready=1. Reloading the same key reproduces k0=0100.
- Integration: 32 keys chained into 32 round instances with plaintext (high,low)=(6565,6877) -> ciphertext (C69B,E9BB).
- ROUNDS=4 override -> exactly 4 keys (the master-key words) are emitted, with rk_last on index 3, then the block returns to IDLE.
